demux_rr_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer that shares the 1-to-4 demultiplexer

---
 rtl/demux_rr_arbiter_if.sv | 26 ++
 rtl/demux_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_demux_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_rr_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the 1-to-4 demux.
interface demux_rr_arbiter_if;
    logic [3:0] req;
    logic [1:0] sel;
    logic       data;
    logic [3:0] grant;
    logic       busy;

    // Requester side: drives requests, observes the arbiter outputs
    modport master (
        output req,
        input  sel,
        input  data,
        input  grant,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req,
        output sel,
        output data,
        output grant,
        output busy
    );
endinterface

// File: rtl/demux_rr_arbiter.sv
// Round-robin sequencer that shares one 1-to-4 demux between four requesters.
// It keeps each grant for a bounded dwell and inserts break-before-make dead
// time between owners.
module demux_rr_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_rr_arbiter_if.slave     bus
);

    localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state, w_state_n;
    logic [1:0]         r_sel,   w_sel_n;
    logic               r_data,  w_data_n;
    logic [3:0]         r_grant, w_grant_n;
    logic               r_busy,  w_busy_n;
    logic [CNT_W-1:0]   r_dwell, w_dwell_n;
    logic [CNT_W-1:0]   r_gap,   w_gap_n;
    logic [1:0]         r_last,  w_last_n;

    logic               w_found;
    logic [1:0]         w_win;

    // Rotating-priority scan: last+1, last+2, last+3, then last itself
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && bus.req[2'(r_last + 2'(k))]) begin
                w_found = 1'b1;
                w_win   = 2'(r_last + 2'(k));
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_data_n  = r_data;
        w_grant_n = r_grant;
        w_dwell_n = r_dwell;
        w_gap_n   = r_gap;
        w_last_n  = r_last;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_n = ST_GRANT;
                    w_sel_n   = w_win;
                    w_data_n  = 1'b1;
                    w_grant_n = 4'(4'b0001 << w_win);
                    w_last_n  = w_win;
                    w_dwell_n = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (!bus.req[r_sel] || (r_dwell == CNT_W'(HOLD_CYCLES))) begin
                    w_state_n = ST_GAP;
                    w_data_n  = 1'b0;
                    w_grant_n = 4'b0000;
                    w_dwell_n = '0;
                    w_gap_n   = CNT_W'(1);
                end else begin
                    w_dwell_n = r_dwell + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_gap == CNT_W'(GAP_CYCLES)) begin
                    w_state_n = ST_IDLE;
                    w_gap_n   = '0;
                end else begin
                    w_gap_n   = r_gap + CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_data_n  = 1'b0;
                w_grant_n = 4'b0000;
                w_dwell_n = '0;
                w_gap_n   = '0;
            end
        endcase

        w_busy_n = (w_state_n != ST_IDLE);
    end

    // State and output registers; pointer resets to 3 so channel 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_data  <= 1'b0;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_dwell <= '0;
            r_gap   <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_data  <= w_data_n;
            r_grant <= w_grant_n;
            r_busy  <= w_busy_n;
            r_dwell <= w_dwell_n;
            r_gap   <= w_gap_n;
            r_last  <= w_last_n;
        end
    end

    assign bus.sel   = r_sel;
    assign bus.data  = r_data;
    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Bench for demux_rr_arbiter: directed scenarios plus random requests,
// every cycle compared against a cycle-level behavioural model.
module tb_demux_rr_arbiter;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    demux_rr_arbiter_if bus ();

    demux_rr_arbiter #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner (-1 = none), cycles held, dead-time edges left
    int         m_owner;
    int         m_held;
    int         m_gap_left;
    int         m_last;
    int         m_sel;
    logic [1:0] e_sel;
    logic       e_data;
    logic [3:0] e_grant;
    logic       e_busy;
    logic [1:0] p_sel;
    logic       p_data;
    int         cyc;

    task automatic model_outputs();
        e_sel   = 2'(m_sel);
        e_data  = (m_owner >= 0);
        e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e_busy  = (m_owner >= 0) || (m_gap_left > 0);
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_held     = 0;
        m_gap_left = 0;
        m_last     = 3;
        m_sel      = 0;
        model_outputs();
    endtask

    // Apply a request vector, advance one clock, update the model, settle
    task automatic tick(input logic [3:0] r);
        int w;
        bus.req = r;
        p_sel   = bus.sel;
        p_data  = bus.data;
        @(posedge clk);
        cyc++;
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_held == HOLD) begin
                m_owner    = -1;
                m_gap_left = GAP;
            end else begin
                m_held++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (r != 4'b0000) begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
            m_owner = w;
            m_held  = 1;
            m_last  = w;
            m_sel   = w;
        end
        model_outputs();
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.req = 4'b0000;
        #3;
        n_checks++;
        if (bus.sel !== 2'd0 || bus.data !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got sel=%0d data=%b grant=%b busy=%b, want 0 0 0000 0",
                     bus.sel, bus.data, bus.grant, bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL idle cyc=%0d: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         cyc, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
        end
    endtask

    task automatic test_sole_requester();
        tick(4'b0100);
        n_checks++;
        if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.data !== 1'b1) begin
            n_fail++;
            $display("FAIL sole_first_latency: got grant=%b sel=%0d data=%b, want 0100 2 1",
                     bus.grant, bus.sel, bus.data);
        end
        for (int i = 0; i < 17; i++) begin
            tick(4'b0100);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL sole cyc=%0d: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         cyc, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
            n_checks++;
            if (!$onehot0(bus.grant) || bus.data !== (|bus.grant) || bus.grant[bus.sel] !== bus.data
                || (p_data && bus.data && bus.sel !== p_sel)) begin
                n_fail++;
                $display("FAIL sole_invariant cyc=%0d: got sel=%0d data=%b grant=%b prev_sel=%0d prev_data=%b",
                         cyc, bus.sel, bus.data, bus.grant, p_sel, p_data);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < HOLD + GAP + 2; i++) tick(4'b0000);
    endtask

    task automatic test_all_requesters();
        drain();
        for (int i = 0; i < 32; i++) begin
            tick(4'b1111);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL all_req cyc=%0d: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         cyc, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
            n_checks++;
            if (!$onehot0(bus.grant) || bus.data !== (|bus.grant) || bus.grant[bus.sel] !== bus.data
                || (p_data && bus.data && bus.sel !== p_sel)) begin
                n_fail++;
                $display("FAIL all_req_invariant cyc=%0d: got sel=%0d data=%b grant=%b prev_sel=%0d prev_data=%b",
                         cyc, bus.sel, bus.data, bus.grant, p_sel, p_data);
            end
        end
    endtask

    task automatic test_short_request();
        logic [3:0] seq [7];
        seq = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
        drain();
        for (int i = 0; i < 7; i++) begin
            tick(seq[i]);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL short_req step=%0d: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         i, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
            if (i == 4) begin
                n_checks++;
                if (bus.grant !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL short_req_pointer: got grant=%b, want 1000", bus.grant);
                end
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] r;
        drain();
        for (int i = 0; i < 8; i++) begin
            r = (i == 0) ? 4'b0010 : 4'b0011;
            tick(r);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL no_preempt step=%0d: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         i, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
            if (i == 3 || i == 6) begin
                n_checks++;
                if (bus.grant !== ((i == 3) ? 4'b0010 : 4'b0001)) begin
                    n_fail++;
                    $display("FAIL no_preempt_owner step=%0d: got grant=%b, want %b",
                             i, bus.grant, (i == 3) ? 4'b0010 : 4'b0001);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        drain();
        tick(4'b0100);
        tick(4'b0100);
        n_checks++;
        if (bus.grant !== e_grant || bus.data !== e_data) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got grant=%b data=%b, want %b %b", bus.grant, bus.data, e_grant, e_data);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.data !== 1'b0 || bus.grant !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got sel=%0d data=%b grant=%b busy=%b, want 0 0 0000 0",
                     bus.sel, bus.data, bus.grant, bus.busy);
        end
        model_reset();
        @(negedge clk);
        reset   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(4'b1001);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL mid_reset_after step=%0d: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         i, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
            if (i == 0) begin
                n_checks++;
                if (bus.grant !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL mid_reset_first_owner: got grant=%b, want 0001", bus.grant);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            tick(r);
            n_checks++;
            if (bus.sel !== e_sel || bus.data !== e_data || bus.grant !== e_grant || bus.busy !== e_busy) begin
                n_fail++;
                $display("FAIL random cyc=%0d req=%b: got sel=%0d data=%b grant=%b busy=%b, want sel=%0d data=%b grant=%b busy=%b",
                         cyc, r, bus.sel, bus.data, bus.grant, bus.busy, e_sel, e_data, e_grant, e_busy);
            end
            n_checks++;
            if (!$onehot0(bus.grant) || bus.data !== (|bus.grant) || bus.grant[bus.sel] !== bus.data
                || (p_data && bus.data && bus.sel !== p_sel)) begin
                n_fail++;
                $display("FAIL random_invariant cyc=%0d: got sel=%0d data=%b grant=%b prev_sel=%0d prev_data=%b",
                         cyc, bus.sel, bus.data, bus.grant, p_sel, p_data);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        p_sel    = 2'd0;
        p_data   = 1'b0;
        model_reset();
        test_reset();
        test_idle();
        test_sole_requester();
        test_all_requesters();
        test_short_request();
        test_no_preempt();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
